// File: rtl/vixen_trace_pkg.sv
// Shared types and constants for the vixen execution-trace transmitter.
// Build option: define VIXEN_TRACE_CYCLE_EN to append a 16-bit cycle delta
// to every record (7-byte records instead of 5).
package vixen_trace_pkg;

  typedef enum logic [1:0] {
    KIND_NORMAL = 2'b00,
    KIND_HALT   = 2'b01,
    KIND_TRAP   = 2'b10
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [3:0]  flags;
    logic [15:0] pc;
    logic [15:0] op;
`ifdef VIXEN_TRACE_CYCLE_EN
    logic [15:0] delta;
`endif
  } rec_t;

`ifdef VIXEN_TRACE_CYCLE_EN
  localparam int REC_BYTES = 7;
`else
  localparam int REC_BYTES = 5;
`endif

  localparam int         REC_W     = REC_BYTES * 8;
  localparam logic [7:0] DROP_MARK = 8'hC0;

  // Wire-order image of a record, first byte in the top bits.
  function automatic logic [REC_W-1:0] rec_pack(input rec_t r);
`ifdef VIXEN_TRACE_CYCLE_EN
    rec_pack = {r.kind, 2'b00, r.flags, r.pc, r.op, r.delta};
`else
    rec_pack = {r.kind, 2'b00, r.flags, r.pc, r.op};
`endif
  endfunction

endpackage

// File: rtl/vixen_trace_fifo.sv
// Record FIFO between the CPU retire port and the serializer.
// Pop data is registered: the popped record appears on pop_data after the
// pop edge and holds there until the next pop, so it doubles as the
// serializer's record holding register.
module vixen_trace_fifo
  import vixen_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t           mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Storage array, no reset needed: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_data <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) begin
        pop_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vixen_trace_tx.sv
// Execution-trace transmitter: captures one record per retired instruction,
// buffers it, and serializes records big-endian onto a valid/ready byte stream.
// Overflow is reported with a 2-byte drop marker (C0, count) instead of
// stalling the CPU. Build option: VIXEN_TRACE_CYCLE_EN adds a cycle delta.
//
//  state  | meaning
//  IDLE   | between records; picks drop marker, next record, or termination
//  SEND   | streaming the record held on the FIFO read register
//  DROP   | streaming the 2-byte drop marker
//  DONE   | trace terminated and drained; stays here until reset
module vixen_trace_tx
  import vixen_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire_valid,
  input  logic [15:0] retire_pc,
  input  logic [15:0] retire_op,
  input  logic [3:0]  retire_flags,
  input  logic        retire_halt,
  input  logic        retire_trap,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP, S_DONE} state_e;

  localparam logic [2:0] LAST_REC = 3'(REC_BYTES - 1);

  state_e           state;
  logic [2:0]       idx;
  logic [7:0]       drop_cnt;
  logic [7:0]       mark_cnt;
  logic             stopped;
  rec_t             wr_rec;
  rec_t             rd_rec;
  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             drop;
  logic             pop;
  logic [REC_W-1:0] rec_bytes;

  // Retires after a halt/trap are neither stored nor counted.
  assign accept = retire_valid && !stopped;
  assign push   = accept && !full;
  assign drop   = accept && full;
  assign pop    = (state == S_IDLE) && (drop_cnt == 8'd0) && !empty;

`ifdef VIXEN_TRACE_CYCLE_EN
  logic [15:0] cyc_cnt;
  logic [15:0] delta_next;

  assign delta_next = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;

  // Clocks since the last stored retire; dropped retires leave it running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_cnt <= '0;
    else        cyc_cnt <= push ? 16'd0 : delta_next;
  end
`endif

  // Assemble the incoming record; trap takes precedence over halt.
  always_comb begin
    wr_rec       = '0;
    wr_rec.kind  = retire_trap ? KIND_TRAP : (retire_halt ? KIND_HALT : KIND_NORMAL);
    wr_rec.flags = retire_flags;
    wr_rec.pc    = retire_pc;
    wr_rec.op    = retire_op;
`ifdef VIXEN_TRACE_CYCLE_EN
    wr_rec.delta = delta_next;
`endif
  end

  vixen_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_rec),
    .pop       (pop),
    .pop_data  (rd_rec),
    .full      (full),
    .empty     (empty)
  );

  assign rec_bytes = rec_pack(rd_rec);

  // Serializer FSM with drop accounting and stop tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      drop_cnt <= '0;
      mark_cnt <= '0;
      stopped  <= 1'b0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (accept && (retire_halt || retire_trap)) stopped <= 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (drop_cnt != 8'd0) begin
            // Marker takes the count; a drop on this same edge starts the next tally.
            state    <= S_DROP;
            mark_cnt <= drop_cnt;
            drop_cnt <= {7'd0, drop};
            tx_valid <= 1'b1;
          end else if (!empty) begin
            state    <= S_SEND;
            tx_valid <= 1'b1;
          end else if (stopped) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_SEND: begin
          if (tx_valid && tx_ready) begin
            if (idx == LAST_REC) begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_DROP: begin
          if (tx_valid && tx_ready) begin
            if (idx == 3'd1) begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end
      endcase
    end
  end

  // Current byte selected from the held record or the marker.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      S_SEND: begin
        for (int i = 0; i < REC_BYTES; i++) begin
          if (idx == 3'(i)) tx_data = rec_bytes[REC_W-1-8*i -: 8];
        end
      end
      S_DROP:  tx_data = (idx == 3'd0) ? DROP_MARK : mark_cnt;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vixen_trace_tx.sv
// Directed bench for vixen_trace_tx (DEPTH = 4).
module tb_vixen_trace_tx;
  import vixen_trace_pkg::*;

  localparam int RB = REC_BYTES;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire_valid = 1'b0;
  logic [15:0] retire_pc = '0;
  logic [15:0] retire_op = '0;
  logic [3:0]  retire_flags = '0;
  logic        retire_halt = 1'b0;
  logic        retire_trap = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  vixen_trace_tx #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_op    (retire_op),
    .retire_flags (retire_flags),
    .retire_halt  (retire_halt),
    .retire_trap  (retire_trap),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .done         (done)
  );

  // Byte sink: a byte counts when valid and ready meet ahead of the next rising edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    retire_valid = 1'b0;
    step(3);
    q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [15:0] pc, input logic [15:0] op, input logic [3:0] fl,
                       input logic hlt, input logic trp);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_op    = op;
    retire_flags = fl;
    retire_halt  = hlt;
    retire_trap  = trp;
  endtask

  task automatic retire(input logic [15:0] pc, input logic [15:0] op, input logic [3:0] fl,
                        input logic hlt, input logic trp);
    drive(pc, op, fl, hlt, trp);
    step(1);
    retire_valid = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      step(1);
      c++;
    end
    chk({tag, "_arrived"}, 32'(q.size() >= n), 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input logic [1:0] kind, input logic [3:0] fl,
                                          input logic [15:0] pc, input logic [15:0] op,
                                          input int k);
    case (k)
      0:       return {kind, 2'b00, fl};
      1:       return pc[15:8];
      2:       return pc[7:0];
      3:       return op[15:8];
      default: return op[7:0];
    endcase
  endfunction

  task automatic check_rec(input string tag, input int base, input logic [1:0] kind,
                           input logic [3:0] fl, input logic [15:0] pc, input logic [15:0] op);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_b%0d", tag, k), 32'(q[base+k]), 32'(exp_byte(kind, fl, pc, op, k)));
    end
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_done", 32'(done), 32'd0);
    do_reset();

    // Single record and retire-to-valid latency
    tx_ready = 1'b1;
    retire(16'h0100, 16'h1234, 4'b0100, 1'b0, 1'b0);
    chk("lat_edge1_valid", 32'(tx_valid), 32'd0);
    step(1);
    chk("lat_edge2_valid", 32'(tx_valid), 32'd1);
    chk("lat_edge2_byte0", 32'(tx_data), 32'h04);
    wait_bytes("single", RB, 40);
    check_rec("single", 0, 2'b00, 4'b0100, 16'h0100, 16'h1234);
    step(5);
    chk("single_count", 32'(q.size()), 32'(RB));
    chk("single_done", 32'(done), 32'd0);

    // Halt record, done timing, and retires ignored afterwards
    do_reset();
    tx_ready = 1'b1;
    retire(16'h0010, 16'hFFFF, 4'b0000, 1'b1, 1'b0);
    wait_bytes("halt", RB, 40);
    check_rec("halt", 0, 2'b01, 4'b0000, 16'h0010, 16'hFFFF);
    chk("halt_done_at_last", 32'(done), 32'd0);
    step(1);
    chk("halt_done_after", 32'(done), 32'd1);
    retire(16'h0020, 16'h1111, 4'b1111, 1'b0, 1'b0);
    step(10);
    chk("halt_no_more_bytes", 32'(q.size()), 32'(RB));
    chk("halt_valid_low", 32'(tx_valid), 32'd0);
    chk("halt_done_held", 32'(done), 32'd1);

    // Stalled sink, 8 back-to-back retires: one record in the serializer,
    // four in the FIFO, three dropped. The marker precedes the FIFO records.
    do_reset();
    tx_ready = 1'b0;
    step(10);
    for (int i = 0; i < 8; i++) begin
      drive(16'h0200 + 16'(i), 16'hA000 + 16'(i), 4'(i + 1), 1'b0, 1'b0);
      step(1);
    end
    retire_valid = 1'b0;
    chk("stall_valid", 32'(tx_valid), 32'd1);
    chk("stall_byte_a", 32'(tx_data), 32'h01);
    step(5);
    chk("stall_byte_b", 32'(tx_data), 32'h01);
    chk("stall_nothing_taken", 32'(q.size()), 32'd0);
    tx_ready = 1'b1;
    wait_bytes("ovf", 5 * RB + 2, 200);
    check_rec("ovf_r0", 0, 2'b00, 4'd1, 16'h0200, 16'hA000);
    chk("ovf_mark", 32'(q[RB]), 32'hC0);
    chk("ovf_cnt", 32'(q[RB+1]), 32'h03);
    check_rec("ovf_r1", RB + 2, 2'b00, 4'd2, 16'h0201, 16'hA001);
    check_rec("ovf_r4", 4 * RB + 2, 2'b00, 4'd5, 16'h0204, 16'hA004);
    step(10);
    chk("ovf_total", 32'(q.size()), 32'(5 * RB + 2));
    chk("ovf_done", 32'(done), 32'd0);

    // 300 retires into a stalled sink: drop count saturates at FF
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(16'(i), ~16'(i), 4'b0000, 1'b0, 1'b0);
      step(1);
    end
    retire_valid = 1'b0;
    tx_ready = 1'b1;
    wait_bytes("sat", 5 * RB + 2, 200);
    check_rec("sat_r0", 0, 2'b00, 4'd0, 16'd0, 16'hFFFF);
    chk("sat_mark", 32'(q[RB]), 32'hC0);
    chk("sat_cnt", 32'(q[RB+1]), 32'hFF);
    check_rec("sat_r4", 4 * RB + 2, 2'b00, 4'd0, 16'd4, 16'hFFFB);

    // Reset mid-record, then a fresh trap record (halt+trap reports as trap)
    do_reset();
    tx_ready = 1'b1;
    retire(16'h0300, 16'h5555, 4'hA, 1'b0, 1'b0);
    wait_bytes("abort", 2, 40);
    rst_n = 1'b0;
    #1;
    chk("abort_valid_low", 32'(tx_valid), 32'd0);
    chk("abort_data_zero", 32'(tx_data), 32'h00);
    step(2);
    q.delete();
    rst_n = 1'b1;
    step(1);
    retire(16'h0400, 16'h6666, 4'h5, 1'b1, 1'b1);
    wait_bytes("fresh", RB, 40);
    check_rec("fresh", 0, 2'b10, 4'h5, 16'h0400, 16'h6666);
    step(3);
    chk("fresh_count", 32'(q.size()), 32'(RB));
    chk("fresh_done", 32'(done), 32'd1);

`ifdef VIXEN_TRACE_CYCLE_EN
    // Retires 3 clocks apart: second record carries delta 00 03
    do_reset();
    tx_ready = 1'b1;
    retire(16'h0500, 16'h0001, 4'h0, 1'b0, 1'b0);
    step(2);
    retire(16'h0502, 16'h0002, 4'h0, 1'b0, 1'b0);
    wait_bytes("delta", 2 * RB, 60);
    check_rec("delta_r1", RB, 2'b00, 4'h0, 16'h0502, 16'h0002);
    chk("delta_hi", 32'(q[RB+5]), 32'h00);
    chk("delta_lo", 32'(q[RB+6]), 32'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
